// File: rtl/rally_pkg.sv
// Shared definitions for the rally game-state logic: FSM encodings,
// tile geometry, spawn position and level count.
package rally_pkg;

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_DONE = 2'd1,
      ST_OVER = 2'd2
   } state_t;

   // Pixel coordinates are tile * 32; low bits zero means tile-aligned.
   localparam int TILE_SHIFT = 5;

   // Player spawn tile; no level places a flag here.
   localparam logic [4:0] SPAWN_TX = 5'd5;
   localparam logic [3:0] SPAWN_TY = 4'd7;

   localparam int N_LEVELS = 4;
   localparam int LEVEL_W  = 2;

endpackage

// File: rtl/flag_rom.sv
// Flag tile table: four flags per level, four levels. Purely combinational.
module flag_rom
   import rally_pkg::*;
(
   input  logic [LEVEL_W-1:0] level_id,
   input  logic [1:0]         idx,
   output logic [4:0]         fx,
   output logic [3:0]         fy
);

   // Look up the tile of flag idx on the current level.
   always_comb begin
      fx = 5'd0;
      fy = 4'd0;
      case ({level_id, idx})
         4'b00_00: begin fx = 5'd2;  fy = 4'd2;  end
         4'b00_01: begin fx = 5'd17; fy = 4'd2;  end
         4'b00_10: begin fx = 5'd2;  fy = 4'd12; end
         4'b00_11: begin fx = 5'd17; fy = 4'd12; end
         4'b01_00: begin fx = 5'd4;  fy = 4'd3;  end
         4'b01_01: begin fx = 5'd26; fy = 4'd4;  end
         4'b01_10: begin fx = 5'd10; fy = 4'd13; end
         4'b01_11: begin fx = 5'd28; fy = 4'd14; end
         4'b10_00: begin fx = 5'd15; fy = 4'd1;  end
         4'b10_01: begin fx = 5'd8;  fy = 4'd9;  end
         4'b10_10: begin fx = 5'd22; fy = 4'd10; end
         4'b10_11: begin fx = 5'd30; fy = 4'd6;  end
         4'b11_00: begin fx = 5'd1;  fy = 4'd14; end
         4'b11_01: begin fx = 5'd12; fy = 4'd5;  end
         4'b11_10: begin fx = 5'd20; fy = 4'd12; end
         4'b11_11: begin fx = 5'd27; fy = 4'd2;  end
         default:  begin fx = 5'd0;  fy = 4'd0;  end
      endcase
   end

endmodule

// File: rtl/flag_tracker.sv
// Game-state stage: scans the level's flags against the player position,
// keeps score and fuel, and sequences level advance and game over.
// dbg_state mirrors the FSM state register for observation.
module flag_tracker
   import rally_pkg::*;
#(
   parameter int N_FLAGS     = 4,
   parameter int DONE_CYCLES = 50_000_000,
   parameter int FUEL_INIT   = 1000,
   parameter int FUEL_TICK   = 5_000_000,
   parameter int FLAG_POINTS = 100
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [9:0]           player_x,
   input  logic [9:0]           player_y,
   input  logic                 start,
   output logic [LEVEL_W-1:0]   level_id,
   output logic [N_FLAGS-1:0]   flags_taken,
   output logic [15:0]          score,
   output logic [9:0]           fuel,
   output logic                 player_rst,
   output logic                 level_up,
   output logic                 game_over,
   output state_t               dbg_state
);

   localparam int IDX_W = (N_FLAGS > 1)     ? $clog2(N_FLAGS)     : 1;
   localparam int FC_W  = (FUEL_TICK > 1)   ? $clog2(FUEL_TICK)   : 1;
   localparam int DC_W  = (DONE_CYCLES > 1) ? $clog2(DONE_CYCLES) : 1;

   state_t              r_state;
   logic [IDX_W-1:0]    r_idx;
   logic [N_FLAGS-1:0]  r_flags;
   logic [15:0]         r_score;
   logic [9:0]          r_fuel;
   logic [FC_W-1:0]     r_fuel_cnt;
   logic [DC_W-1:0]     r_done_cnt;
   logic [LEVEL_W-1:0]  r_level;
   logic                r_player_rst;
   logic                r_level_up;
   logic                r_game_over;

   logic [4:0]          w_fx;
   logic [3:0]          w_fy;
   logic                w_aligned;
   logic                w_tile_match;
   logic                w_hit;
   logic [N_FLAGS-1:0]  w_flags_next;
   logic                w_final_hit;
   logic                w_fuel_tick;
   logic [16:0]         w_score_sum;
   logic [15:0]         w_score_sat;
   logic [IDX_W-1:0]    w_idx_next;
   logic                w_unused_y;

   flag_rom u_flag_rom (
      .level_id (r_level),
      .idx      (2'(r_idx)),
      .fx       (w_fx),
      .fy       (w_fy)
   );

   // Playfield is 16 tiles tall, so the top y bit never selects a tile.
   assign w_unused_y   = player_y[9];

   assign w_aligned    = (player_x[TILE_SHIFT-1:0] == '0) && (player_y[TILE_SHIFT-1:0] == '0);
   assign w_tile_match = (player_x[9:TILE_SHIFT] == w_fx) && (player_y[8:TILE_SHIFT] == w_fy);
   assign w_hit        = w_aligned && w_tile_match && !r_flags[r_idx];
   assign w_flags_next = r_flags | (w_hit ? (N_FLAGS'(1) << r_idx) : '0);
   assign w_final_hit  = w_hit && (&w_flags_next);
   assign w_fuel_tick  = (r_fuel_cnt == FC_W'(FUEL_TICK - 1));
   assign w_score_sum  = {1'b0, r_score} + 17'(FLAG_POINTS);
   assign w_score_sat  = w_score_sum[16] ? 16'hFFFF : w_score_sum[15:0];
   assign w_idx_next   = (r_idx == IDX_W'(N_FLAGS - 1)) ? '0 : r_idx + IDX_W'(1);

   // Game FSM with scan, fuel, score and pulse registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_RUN;
         r_idx        <= '0;
         r_flags      <= '0;
         r_score      <= '0;
         r_fuel       <= 10'(FUEL_INIT);
         r_fuel_cnt   <= '0;
         r_done_cnt   <= '0;
         r_level      <= '0;
         r_player_rst <= 1'b1;
         r_level_up   <= 1'b0;
         r_game_over  <= 1'b0;
      end else begin
         r_player_rst <= 1'b0;
         r_level_up   <= 1'b0;
         case (r_state)
            ST_RUN: begin
               if (&r_flags) begin
                  r_state    <= ST_DONE;
                  r_done_cnt <= '0;
               end else if (r_fuel == '0) begin
                  r_state     <= ST_OVER;
                  r_game_over <= 1'b1;
               end else begin
                  r_idx <= w_idx_next;
                  if (w_hit) begin
                     r_flags <= w_flags_next;
                     r_score <= w_score_sat;
                  end
                  if (w_fuel_tick) begin
                     r_fuel_cnt <= '0;
                     // Collecting the last flag wins over running dry on the same edge.
                     if (!(w_final_hit && r_fuel == 10'd1))
                        r_fuel <= r_fuel - 10'd1;
                  end else begin
                     r_fuel_cnt <= r_fuel_cnt + FC_W'(1);
                  end
               end
            end
            ST_DONE: begin
               if (r_done_cnt == DC_W'(DONE_CYCLES - 1)) begin
                  r_state      <= ST_RUN;
                  r_level      <= r_level + LEVEL_W'(1);
                  r_flags      <= '0;
                  r_fuel       <= 10'(FUEL_INIT);
                  r_fuel_cnt   <= '0;
                  r_idx        <= '0;
                  r_player_rst <= 1'b1;
                  r_level_up   <= 1'b1;
               end else begin
                  r_done_cnt <= r_done_cnt + DC_W'(1);
               end
            end
            ST_OVER: begin
               if (start) begin
                  r_state      <= ST_RUN;
                  r_level      <= '0;
                  r_score      <= '0;
                  r_flags      <= '0;
                  r_fuel       <= 10'(FUEL_INIT);
                  r_fuel_cnt   <= '0;
                  r_idx        <= '0;
                  r_player_rst <= 1'b1;
                  r_game_over  <= 1'b0;
               end
            end
            default: r_state <= ST_RUN;
         endcase
      end
   end

   assign level_id    = r_level;
   assign flags_taken = r_flags;
   assign score       = r_score;
   assign fuel        = r_fuel;
   assign player_rst  = r_player_rst;
   assign level_up    = r_level_up;
   assign game_over   = r_game_over;
   assign dbg_state   = r_state;

endmodule

// File: tb/tb_flag_tracker.sv
// Directed bench for flag_tracker with short timing parameters.
module tb_flag_tracker;
   import rally_pkg::*;

   localparam int N_FLAGS     = 4;
   localparam int DONE_CYCLES = 8;
   localparam int FUEL_INIT   = 5;
   localparam int FUEL_TICK   = 16;
   localparam int FLAG_POINTS = 100;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [9:0]   player_x;
   logic [9:0]   player_y;
   logic         start;
   logic [1:0]   level_id;
   logic [3:0]   flags_taken;
   logic [15:0]  score;
   logic [9:0]   fuel;
   logic         player_rst;
   logic         level_up;
   logic         game_over;
   state_t       dbg_state;

   int checks = 0;
   int errors = 0;
   int cyc_cnt = 0;
   int r_edge;
   int pulses;

   // Hand-written flag tables (tile units), one row per level.
   int fx_tab [4][4] = '{'{2, 17, 2, 17}, '{4, 26, 10, 28}, '{15, 8, 22, 30}, '{1, 12, 20, 27}};
   int fy_tab [4][4] = '{'{2, 2, 12, 12}, '{3, 4, 13, 14}, '{1, 9, 10, 6}, '{14, 5, 12, 2}};

   flag_tracker #(
      .N_FLAGS     (N_FLAGS),
      .DONE_CYCLES (DONE_CYCLES),
      .FUEL_INIT   (FUEL_INIT),
      .FUEL_TICK   (FUEL_TICK),
      .FLAG_POINTS (FLAG_POINTS)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .player_x    (player_x),
      .player_y    (player_y),
      .start       (start),
      .level_id    (level_id),
      .flags_taken (flags_taken),
      .score       (score),
      .fuel        (fuel),
      .player_rst  (player_rst),
      .level_up    (level_up),
      .game_over   (game_over),
      .dbg_state   (dbg_state)
   );

   // Clock and edge counter.
   always #5 clk = ~clk;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   // Global time limit.
   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic place(input int tx, input int ty);
      player_x = 10'(tx * 32);
      player_y = 10'(ty * 32);
   endtask

   // Stand on flag f of level lvl until its bit sets (at most N_FLAGS edges).
   task automatic take_flag(input int lvl, input int f, input string tag);
      int n;
      n = 0;
      place(fx_tab[lvl][f], fy_tab[lvl][f]);
      while (flags_taken[f] !== 1'b1 && n < N_FLAGS) begin
         cyc(1);
         n++;
      end
      chk(tag, 32'(flags_taken[f]), 1);
   endtask

   // Step one edge at a time until DONE is seen (bounded).
   task automatic wait_done(input string tag);
      int n;
      n = 0;
      while (dbg_state !== ST_DONE && n < 12) begin
         cyc(1);
         n++;
      end
      chk(tag, 32'(dbg_state), 32'(ST_DONE));
   endtask

   // Called at the first sample after DONE entry: pulse must land exactly DONE_CYCLES later.
   task automatic advance_check(input int new_lvl, input string tag);
      int early;
      early = 0;
      for (int k = 1; k < DONE_CYCLES; k++) begin
         cyc(1);
         if (level_up === 1'b1 || player_rst === 1'b1) early++;
      end
      chk({tag, "_early"}, early, 0);
      cyc(1);
      chk({tag, "_level_up"}, 32'(level_up), 1);
      chk({tag, "_player_rst"}, 32'(player_rst), 1);
      chk({tag, "_level_id"}, 32'(level_id), new_lvl);
      chk({tag, "_flags"}, 32'(flags_taken), 0);
      chk({tag, "_fuel"}, 32'(fuel), FUEL_INIT);
      chk({tag, "_state"}, 32'(dbg_state), 32'(ST_RUN));
      cyc(1);
      chk({tag, "_level_up_1cyc"}, 32'(level_up), 0);
      chk({tag, "_player_rst_1cyc"}, 32'(player_rst), 0);
   endtask

   initial begin
      // Reset
      rst_n = 1'b0;
      start = 1'b0;
      place(5, 7);
      cyc(2);
      chk("rst_player_rst", 32'(player_rst), 1);
      chk("rst_fuel", 32'(fuel), FUEL_INIT);
      chk("rst_score", 32'(score), 0);
      chk("rst_level", 32'(level_id), 0);
      chk("rst_flags", 32'(flags_taken), 0);
      chk("rst_game_over", 32'(game_over), 0);
      chk("rst_level_up", 32'(level_up), 0);
      chk("rst_state", 32'(dbg_state), 32'(ST_RUN));
      rst_n = 1'b1;
      cyc(1);
      chk("rel_player_rst", 32'(player_rst), 0);

      // Unaligned position on a flag tile: no pickup
      player_x = 10'd65;
      player_y = 10'd64;
      cyc(6);
      chk("unaligned_flags", 32'(flags_taken), 0);
      chk("unaligned_score", 32'(score), 0);

      // First flag at (64,64), then hold: no double count
      place(2, 2);
      cyc(4);
      chk("flag0_flags", 32'(flags_taken), 4'b0001);
      chk("flag0_score", 32'(score), 100);
      cyc(50);
      chk("hold_score", 32'(score), 100);
      chk("hold_flags", 32'(flags_taken), 4'b0001);
      chk("hold_fuel", 32'(fuel), 2);

      // Remaining level-0 flags, level advance
      take_flag(0, 1, "l0_flag1");
      take_flag(0, 2, "l0_flag2");
      take_flag(0, 3, "l0_flag3");
      chk("l0_all_flags", 32'(flags_taken), 4'hF);
      chk("l0_score", 32'(score), 400);
      wait_done("l0_done");
      chk("l0_done_fuel", 32'(fuel), 1);
      advance_check(1, "l0_adv");
      chk("l1_score_kept", 32'(score), 400);

      // Level 1: no pickups, start ignored in RUN, fuel runs out
      place(5, 7);
      start = 1'b1;
      cyc(1);
      start = 1'b0;
      chk("run_start_ignored_rst", 32'(player_rst), 0);
      chk("run_start_ignored_lvl", 32'(level_id), 1);
      cyc(77);
      chk("fuel_before_empty", 32'(fuel), 1);
      chk("go_before_empty", 32'(game_over), 0);
      cyc(1);
      chk("fuel_empty", 32'(fuel), 0);
      chk("go_at_empty", 32'(game_over), 0);
      cyc(1);
      chk("game_over_set", 32'(game_over), 1);
      chk("over_state", 32'(dbg_state), 32'(ST_OVER));
      cyc(3);
      chk("over_hold_fuel", 32'(fuel), 0);
      chk("over_hold_score", 32'(score), 400);
      chk("over_hold_level", 32'(level_id), 1);
      chk("over_hold_go", 32'(game_over), 1);

      // Restart
      start = 1'b1;
      cyc(1);
      start = 1'b0;
      r_edge = cyc_cnt;
      chk("restart_player_rst", 32'(player_rst), 1);
      chk("restart_go", 32'(game_over), 0);
      chk("restart_score", 32'(score), 0);
      chk("restart_level", 32'(level_id), 0);
      chk("restart_fuel", 32'(fuel), FUEL_INIT);
      chk("restart_flags", 32'(flags_taken), 0);
      chk("restart_state", 32'(dbg_state), 32'(ST_RUN));
      cyc(1);
      chk("restart_player_rst_drop", 32'(player_rst), 0);

      // Final flag on the same edge that fuel would hit zero (edge 80 after restart, idx 3)
      take_flag(0, 0, "sim_flag0");
      take_flag(0, 1, "sim_flag1");
      take_flag(0, 2, "sim_flag2");
      while (cyc_cnt < r_edge + 79) cyc(1);
      chk("sim_fuel_pre", 32'(fuel), 1);
      chk("sim_flags_pre", 32'(flags_taken), 4'b0111);
      place(17, 12);
      cyc(1);
      chk("sim_flags", 32'(flags_taken), 4'hF);
      chk("sim_score", 32'(score), 400);
      chk("sim_fuel_kept", 32'(fuel), 1);
      wait_done("sim_done");
      chk("sim_no_over", 32'(game_over), 0);
      advance_check(1, "sim_adv");

      // Level 1 complete, then level 2 up to DONE
      for (int f = 0; f < 4; f++) take_flag(1, f, "l1_flag");
      chk("l1_score", 32'(score), 800);
      wait_done("l1_done");
      advance_check(2, "l1_adv");
      for (int f = 0; f < 4; f++) take_flag(2, f, "l2_flag");
      wait_done("l2_done");
      chk("l2_score", 32'(score), 1200);
      chk("l2_level", 32'(level_id), 2);

      // Asynchronous reset in the middle of DONE
      cyc(3);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_level", 32'(level_id), 0);
      chk("arst_flags", 32'(flags_taken), 0);
      chk("arst_score", 32'(score), 0);
      chk("arst_fuel", 32'(fuel), FUEL_INIT);
      chk("arst_player_rst", 32'(player_rst), 1);
      chk("arst_level_up", 32'(level_up), 0);
      chk("arst_state", 32'(dbg_state), 32'(ST_RUN));
      pulses = 0;
      repeat (12) begin
         cyc(1);
         if (level_up === 1'b1) pulses++;
      end
      chk("arst_no_level_up", pulses, 0);
      rst_n = 1'b1;
      cyc(1);
      chk("arst_rel_player_rst", 32'(player_rst), 0);
      chk("arst_rel_level", 32'(level_id), 0);
      chk("arst_rel_level_up", 32'(level_up), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
